// File: rtl/i2s_rx_deser_if.sv
// Sample-pair delivery bus for the I2S receiver.
//   left/right : captured left/right samples of the current pair
//   valid      : a pair is being offered
//   ready      : consumer takes the pair on valid & ready
//   overflow   : sticky flag, a completed pair had to be dropped
//   ovf_clr    : one-cycle pulse that clears overflow
//   frame_err  : one-cycle pulse, LRCLK moved before a word was complete
// master = receiver side, slave = consumer side.
interface i2s_rx_deser_if #(
   parameter int DATA_W = 24
);
   logic [DATA_W-1:0] left;
   logic [DATA_W-1:0] right;
   logic              valid;
   logic              ready;
   logic              overflow;
   logic              ovf_clr;
   logic              frame_err;

   modport master (
      output left, right, valid, overflow, frame_err,
      input  ready, ovf_clr
   );

   modport slave (
      input  left, right, valid, overflow, frame_err,
      output ready, ovf_clr
   );
endinterface

// File: rtl/i2s_rx_deser.sv
// I2S slave receiver. The SCLK/LRCLK/SDATA pins are synchronised into the
// i_clk domain. MSB-first words are deserialised on each rising SCLK edge,
// and left/right sample pairs are handed out over a valid/ready handshake.
//   i_clk   : system clock, at least 4x SCLK
//   i_rst   : synchronous reset, active high
//   i_sclk  : I2S bit clock (asynchronous)
//   i_rlclk : I2S word select (asynchronous)
//   i_sdata : I2S serial data (asynchronous)
//   bus     : pair output, handshake and status (see i2s_rx_deser_if)
module i2s_rx_deser #(
   parameter int DATA_W      = 24,
   parameter int SYNC_STAGES = 2,
   parameter int LEFT_LEVEL  = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_sclk,
   input  logic                  i_rlclk,
   input  logic                  i_sdata,
   i2s_rx_deser_if.master        bus
);

   localparam int   CNT_W    = $clog2(DATA_W + 1);
   localparam logic LEFT_BIT = (LEFT_LEVEL != 0);

   typedef enum logic [1:0] {ST_SYNC, ST_DELAY, ST_SHIFT, ST_DONE} state_t;

   // Input synchronisers and edge detection.
   logic [SYNC_STAGES-1:0] sclk_sync_reg, lr_sync_reg, sd_sync_reg;
   logic                   sclk_dly_reg, lr_prev_reg;
   logic                   sclk_s, lr_s, sd_s, rise, lr_change;

   assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
   assign lr_s      = lr_sync_reg[SYNC_STAGES-1];
   assign sd_s      = sd_sync_reg[SYNC_STAGES-1];
   assign rise      = sclk_s & ~sclk_dly_reg;
   assign lr_change = rise & (lr_s != lr_prev_reg);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sclk_sync_reg <= '0;
         lr_sync_reg   <= '0;
         sd_sync_reg   <= '0;
         sclk_dly_reg  <= 1'b0;
         lr_prev_reg   <= 1'b0;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], i_sclk};
         lr_sync_reg   <= {lr_sync_reg[SYNC_STAGES-2:0], i_rlclk};
         sd_sync_reg   <= {sd_sync_reg[SYNC_STAGES-2:0], i_sdata};
         sclk_dly_reg  <= sclk_s;
         // LRCLK history is only meaningful at bit-clock granularity.
         if (rise) begin
            lr_prev_reg <= lr_s;
         end
      end
   end

   // Deserialiser FSM.
   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    count_reg, count_next;
   logic [DATA_W-1:0]   shift_reg, shift_next;
   logic                cap_left, cap_right, abort_left, frame_err_next;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= ST_SYNC;
         count_reg <= '0;
         shift_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         shift_reg <= shift_next;
      end
   end

   // The rise on which an LR change is seen is the I2S one-bit delay slot,
   // so DELAY only lasts one i_clk: the following rise carries the MSB.
   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      shift_next     = shift_reg;
      cap_left       = 1'b0;
      cap_right      = 1'b0;
      abort_left     = 1'b0;
      frame_err_next = 1'b0;
      case (state_reg)
         ST_SYNC: begin
            if (lr_change && (lr_s == LEFT_BIT)) begin
               state_next = ST_DELAY;
            end
         end
         ST_DELAY: begin
            state_next = ST_SHIFT;
            count_next = '0;
         end
         ST_SHIFT: begin
            if (lr_change) begin
               frame_err_next = 1'b1;
               abort_left     = (lr_prev_reg == LEFT_BIT);
               state_next     = ST_DELAY;
            end else if (rise) begin
               shift_next = (shift_reg << 1) | DATA_W'(sd_s);
               count_next = count_reg + CNT_W'(1);
               if (count_reg == CNT_W'(DATA_W - 1)) begin
                  if (lr_s == LEFT_BIT) begin
                     cap_left = 1'b1;
                  end else begin
                     cap_right = 1'b1;
                  end
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (lr_change) begin
               state_next = ST_DELAY;
            end
         end
         default: state_next = ST_SYNC;
      endcase
   end

   // Word staging, pairing and output handshake.
   logic [DATA_W-1:0] left_word_reg, right_word_reg;
   logic [DATA_W-1:0] left_out_reg, right_out_reg;
   logic              left_pend_reg, pair_strobe_reg;
   logic              valid_reg, overflow_reg, frame_err_reg;
   logic              pair_drop;

   // A new pair arrives while the held one is neither empty nor leaving.
   assign pair_drop = pair_strobe_reg & valid_reg & ~bus.ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         left_word_reg   <= '0;
         right_word_reg  <= '0;
         left_out_reg    <= '0;
         right_out_reg   <= '0;
         left_pend_reg   <= 1'b0;
         pair_strobe_reg <= 1'b0;
         valid_reg       <= 1'b0;
         overflow_reg    <= 1'b0;
         frame_err_reg   <= 1'b0;
      end else begin
         frame_err_reg   <= frame_err_next;
         pair_strobe_reg <= cap_right & left_pend_reg;
         if (cap_left) begin
            left_word_reg <= shift_next;
            left_pend_reg <= 1'b1;
         end else if (abort_left || cap_right) begin
            // A right word consumes the pending left (or is orphaned).
            left_pend_reg <= 1'b0;
         end
         if (cap_right) begin
            right_word_reg <= shift_next;
         end

         if (pair_strobe_reg && (!valid_reg || bus.ready)) begin
            left_out_reg  <= left_word_reg;
            right_out_reg <= right_word_reg;
            valid_reg     <= 1'b1;
         end else if (valid_reg && bus.ready) begin
            valid_reg <= 1'b0;
         end

         // Setting wins over a simultaneous clear.
         if (pair_drop) begin
            overflow_reg <= 1'b1;
         end else if (bus.ovf_clr) begin
            overflow_reg <= 1'b0;
         end
      end
   end

   assign bus.left      = left_out_reg;
   assign bus.right     = right_out_reg;
   assign bus.valid     = valid_reg;
   assign bus.overflow  = overflow_reg;
   assign bus.frame_err = frame_err_reg;

endmodule

// File: tb/tb_i2s_rx_deser.sv
`timescale 1ns/1ps
module tb_i2s_rx_deser;

   logic clk = 1'b0;
   logic rst;
   logic sclk, lrclk, sdata;

   always #5 clk = ~clk;

   i2s_rx_deser_if #(.DATA_W(24)) bus ();

   i2s_rx_deser #(
      .DATA_W(24),
      .SYNC_STAGES(2),
      .LEFT_LEVEL(1)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_sclk (sclk),
      .i_rlclk(lrclk),
      .i_sdata(sdata),
      .bus    (bus)
   );

   int  n_checks = 0;
   int  n_errors = 0;
   int  pair_cnt = 0;
   int  valid_cyc = 0;
   int  ferr_cnt = 0;
   logic [23:0] last_l = '0;
   logic [23:0] last_r = '0;
   time last_rise_t = 0;
   time valid_rise_t = 0;
   logic valid_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor on the falling clock edge, away from DUT updates.
   always @(negedge clk) begin
      if (bus.valid && bus.ready) begin
         pair_cnt++;
         last_l = bus.left;
         last_r = bus.right;
         $display("pair %0d: L=0x%06h R=0x%06h", pair_cnt, bus.left, bus.right);
      end
      if (bus.valid) valid_cyc++;
      if (bus.frame_err) ferr_cnt++;
      if (bus.valid && !valid_prev) valid_rise_t = $time;
      valid_prev = bus.valid;
   end

   task automatic wait_clk(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One SCLK period: data/LR change while low, 24 clk per half.
   task automatic sclk_bit(input logic lr, input logic d, input logic mark);
      lrclk = lr;
      sdata = d;
      wait_clk(24);
      sclk = 1'b1;
      if (mark) last_rise_t = $time - 1;
      wait_clk(24);
      sclk = 1'b0;
   endtask

   // Slot of nbits rises: rise 0 = delay slot, 1..24 = word MSB first, rest = fill.
   task automatic send_slot(input logic lr, input logic [23:0] w, input logic fill, input int nbits);
      logic b;
      for (int i = 0; i < nbits; i++) begin
         if (i == 0 || i > 24) b = fill;
         else b = w[24 - i];
         sclk_bit(lr, b, (i == 24));
      end
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input logic fill);
      send_slot(1'b1, l, fill, 32);
      send_slot(1'b0, r, fill, 32);
      $display("frame sent: L=0x%06h R=0x%06h", l, r);
   endtask

   int p0, f0;
   logic [23:0] wpart;

   initial begin
      rst = 1'b1;
      sclk = 1'b0;
      lrclk = 1'b0;
      sdata = 1'b0;
      bus.ready = 1'b1;
      bus.ovf_clr = 1'b0;
      wait_clk(5);
      rst = 1'b0;
      wait_clk(2);

      check("rst_valid", bus.valid, 0);
      check("rst_left", bus.left, 0);
      check("rst_right", bus.right, 0);
      check("rst_ovf", bus.overflow, 0);
      check("rst_ferr", bus.frame_err, 0);

      // Start in the right half: nothing until a full L/R pair.
      send_slot(1'b0, 24'h777777, 1'b0, 32);
      wait_clk(10);
      check("right_first_no_pair", pair_cnt, 0);

      send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b0);
      wait_clk(10);
      check("f1_pairs", pair_cnt, 1);
      check("f1_left", last_l, 24'hA5A5A5);
      check("f1_right", last_r, 24'h5A5A5A);
      check("f1_pulse", valid_cyc, 1);
      check("f1_latency", (valid_rise_t - 5 - last_rise_t) / 10, 4);
      check("f1_valid_low", bus.valid, 0);

      send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b0);
      wait_clk(10);
      check("f2_pairs", pair_cnt, 2);
      check("f2_pulse", valid_cyc, 2);

      // Extra slot bits set to 1 are ignored.
      send_frame(24'h123456, 24'h654321, 1'b1);
      wait_clk(10);
      check("extra_left", last_l, 24'h123456);
      check("extra_right", last_r, 24'h654321);

      // LRCLK moves after 10 left bits.
      p0 = pair_cnt;
      f0 = ferr_cnt;
      send_slot(1'b1, 24'hFFFFFF, 1'b0, 11);
      send_slot(1'b0, 24'hABCDEF, 1'b0, 32);
      wait_clk(10);
      check("ferr_pulse", ferr_cnt - f0, 1);
      check("ferr_no_pair", pair_cnt, p0);
      send_frame(24'h0F0F0F, 24'hF0F0F0, 1'b0);
      wait_clk(10);
      check("ferr_next_pairs", pair_cnt, p0 + 1);
      check("ferr_next_left", last_l, 24'h0F0F0F);
      check("ferr_next_right", last_r, 24'hF0F0F0);

      // Overflow with consumer stalled.
      bus.ready = 1'b0;
      send_frame(24'h000001, 24'h000002, 1'b0);
      send_frame(24'h000003, 24'h000004, 1'b0);
      wait_clk(10);
      check("ovf_valid", bus.valid, 1);
      check("ovf_held_left", bus.left, 24'h000001);
      check("ovf_held_right", bus.right, 24'h000002);
      check("ovf_flag", bus.overflow, 1);
      p0 = pair_cnt;
      bus.ready = 1'b1;
      wait_clk(1);
      check("ovf_valid_drop", bus.valid, 0);
      check("ovf_taken", pair_cnt, p0 + 1);
      check("ovf_taken_left", last_l, 24'h000001);
      check("ovf_taken_right", last_r, 24'h000002);
      check("ovf_still_set", bus.overflow, 1);
      bus.ovf_clr = 1'b1;
      wait_clk(1);
      bus.ovf_clr = 1'b0;
      check("ovf_cleared", bus.overflow, 0);
      check("data_hold", bus.left, 24'h000001);

      // Reset in the middle of a left word.
      wpart = 24'h111111;
      send_slot(1'b1, wpart, 1'b0, 10);
      rst = 1'b1;
      wait_clk(1);
      rst = 1'b0;
      wait_clk(1);
      check("mid_rst_left", bus.left, 0);
      check("mid_rst_right", bus.right, 0);
      check("mid_rst_valid", bus.valid, 0);
      p0 = pair_cnt;
      for (int i = 10; i < 32; i++) begin
         sclk_bit(1'b1, (i <= 24) ? wpart[24 - i] : 1'b0, 1'b0);
      end
      send_slot(1'b0, 24'h222222, 1'b0, 32);
      wait_clk(10);
      check("mid_rst_no_partial", pair_cnt, p0);
      send_frame(24'hC0FFEE, 24'h0BEEF0, 1'b0);
      wait_clk(10);
      check("post_rst_pairs", pair_cnt, p0 + 1);
      check("post_rst_left", last_l, 24'hC0FFEE);
      check("post_rst_right", last_r, 24'h0BEEF0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
